key_event_detector: RTL

KEY_EVENT_DETECTOR -- requirements
Module: key_event_detector

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_channel.sv | 145 ++++++++++++++
 rtl/key_event_detector.sv | 60 ++++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key event detector.
//   key_state_e     : per-channel classification FSM state
//   STATE_W         : width of key_state_e, used to flatten state vectors
//   DEF_*           : default timing constants for a 100 Hz tick
//   max_int()       : elaboration-time helper for counter sizing
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_WAIT_GAP  = 3'd3,
        ST_SECOND    = 3'd4
    } key_state_e;

    localparam int STATE_W = $bits(key_state_e);

    localparam int TICK_HZ              = 100;
    localparam int DEF_DEBOUNCE_TICKS   = 2;
    localparam int DEF_LONG_TICKS       = 3 * TICK_HZ;            // 3 s
    localparam int DEF_DOUBLE_GAP_TICKS = (300 * TICK_HZ) / 1000; // 300 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel -- one key: synchroniser, debouncer and press classifier.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   tick          : one-clk timing strobe; all durations count ticks
//   key_raw       : raw asynchronous key level, 1 = pressed
//   key_level     : debounced level
//   short_pulse   : one-clk pulse, short press
//   long_pulse    : one-clk pulse, hold reached LONG_TICKS
//   double_pulse  : one-clk pulse, double press
//   held          : high while in ST_LONG_HELD
//   state         : classification FSM state (debug visibility)
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_TICKS   = DEF_DEBOUNCE_TICKS,
    parameter int LONG_TICKS       = DEF_LONG_TICKS,
    parameter int DOUBLE_GAP_TICKS = DEF_DOUBLE_GAP_TICKS,
    parameter int DOUBLE_EN        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_raw,
    output logic       key_level,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic       held,
    output key_state_e state
);

    localparam int CNT_W = $clog2(max_int(LONG_TICKS, DOUBLE_GAP_TICKS) + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       sync_q;
    logic [DB_W-1:0]  db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             synced;
    logic             db_done;
    logic             db_flip;
    logic             rise;
    logic             fall;

    assign synced  = sync_q[1];
    assign db_done = (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));
    // The debounced edge is seen by the FSM in the same clk that key_level
    // flips; that clk always carries a tick, which the edge then consumes.
    assign db_flip = tick && (synced != key_level) && db_done;
    assign rise    = db_flip && !key_level;
    assign fall    = db_flip && key_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            db_cnt    <= '0;
            key_level <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
            if (synced == key_level) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_done) begin
                    key_level <= ~key_level;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        hold_cnt <= '0;
                        state    <= ST_PRESSED;
                    end
                end
                ST_PRESSED, ST_SECOND: begin
                    if (fall) begin
                        if (state == ST_SECOND) begin
                            double_pulse <= 1'b1;
                            state        <= ST_IDLE;
                        end else if (DOUBLE_EN != 0) begin
                            gap_cnt <= '0;
                            state   <= ST_WAIT_GAP;
                        end else begin
                            short_pulse <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end else if (tick) begin
                        hold_cnt <= sat_inc(hold_cnt);
                        // A long hold in the second press drops the first press.
                        if (hold_cnt == CNT_W'(LONG_TICKS - 1)) begin
                            long_pulse <= 1'b1;
                            held       <= 1'b1;
                            state      <= ST_LONG_HELD;
                        end
                    end
                end
                ST_LONG_HELD: begin
                    if (fall) begin
                        held  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT_GAP: begin
                    if (rise) begin
                        hold_cnt <= '0;
                        state    <= ST_SECOND;
                    end else if (tick) begin
                        gap_cnt <= sat_inc(gap_cnt);
                        if (gap_cnt == CNT_W'(DOUBLE_GAP_TICKS - 1)) begin
                            short_pulse <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    held  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_detector.sv
// key_event_detector -- NUM_KEYS independent key channels.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   tick          : 100 Hz one-clk strobe
//   key_raw       : raw key levels, 1 = pressed
//   key_level     : debounced levels
//   short_pulse / long_pulse / double_pulse : one-clk event pulses
//   held          : high while a channel is in a long hold
//   fsm_state     : per-channel FSM state, channel i at [i*STATE_W +: STATE_W]
module key_event_detector
    import key_pkg::*;
#(
    parameter int NUM_KEYS         = 4,
    parameter int DEBOUNCE_TICKS   = DEF_DEBOUNCE_TICKS,
    parameter int LONG_TICKS       = DEF_LONG_TICKS,
    parameter int DOUBLE_GAP_TICKS = DEF_DOUBLE_GAP_TICKS,
    parameter int DOUBLE_EN        = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [NUM_KEYS-1:0]         key_raw,
    output logic [NUM_KEYS-1:0]         key_level,
    output logic [NUM_KEYS-1:0]         short_pulse,
    output logic [NUM_KEYS-1:0]         long_pulse,
    output logic [NUM_KEYS-1:0]         double_pulse,
    output logic [NUM_KEYS-1:0]         held,
    output logic [NUM_KEYS*STATE_W-1:0] fsm_state
);

    if (NUM_KEYS < 1 || DEBOUNCE_TICKS == 0 || LONG_TICKS == 0 ||
        DOUBLE_GAP_TICKS == 0) begin : g_bad_params
        $error("key_event_detector: NUM_KEYS must be >= 1 and all tick counts non-zero");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_state_e ch_state;

        key_channel #(
            .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
            .LONG_TICKS      (LONG_TICKS),
            .DOUBLE_GAP_TICKS(DOUBLE_GAP_TICKS),
            .DOUBLE_EN       (DOUBLE_EN)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .short_pulse (short_pulse[i]),
            .long_pulse  (long_pulse[i]),
            .double_pulse(double_pulse[i]),
            .held        (held[i]),
            .state       (ch_state)
        );

        assign fsm_state[i*STATE_W +: STATE_W] = ch_state;
    end

endmodule
